traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Passive checker on the two-approach signal-head bus. It decodes the north-south and east-west light codes into an intersection phase and verifies the legal sequence, green/yellow conflicts, illegal codes and per-phase dwell times. Any violation raises a latched fault with a cause code for the safety supervisor. It sits downstream of the traffic light controller, on the same clock, and never drives the lights.

## Interface
- `MIN_GREEN`, default 1: minimum consecutive samples a green phase (P0/P2) must last before it may advance.
- `MIN_YELLOW`, default 1: minimum consecutive samples a yellow phase (P1/P3) must last before it may advance.
- `MAX_DWELL`, default 16: maximum consecutive samples of any one phase; 0 disables the stall check.
- `CNT_W`, default 8: dwell counter width; must satisfy 2^CNT_W-1 > MAX_DWELL.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ns_light` in 2: NS code; 00=Red, 01=Yellow, 10=Green, 11=illegal.
- `ew_light` in 2: EW code; same encoding as `ns_light`.
- `clear` in 1: synchronous fault acknowledge.
- `phase` out 2: decoded phase; 0=NS-G/EW-R, 1=NS-Y/EW-R, 2=NS-R/EW-G, 3=NS-R/EW-Y.
- `phase_valid` out 1: high while tracking and `phase` is current.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: cause; 0=none, 1=conflict, 2=illegal code, 3=sequence, 4=short dwell, 5=stall.
- `dwell` out CNT_W: consecutive samples of the current phase; saturates at all-ones.
- `cycle_count` out 16: completed P3->P0 cycles; wraps.

## Operation
- **Sample register.** `ns_light` and `ew_light` are registered every cycle. All checks use the registered pair.
- **Decode.** (10,00)->P0, (01,00)->P1, (00,10)->P2, (00,01)->P3. Every other pair is a bad pair.
- **Bad-pair classification**, highest cause first:
  - Both codes non-red (neither is 00) -> conflict (1).
  - Either code is 11 -> illegal (2).
  - Remaining cases, including all-red (00,00) -> illegal (2).
- **Monitor FSM: IDLE, TRACK, FAULT.**
- **IDLE** (reset state):
  - Bad pair -> FAULT.
  - P0 -> TRACK, with `dwell`=1.
  - P1/P2/P3 -> stay in IDLE; no fault.
- **TRACK:**
  - Same phase -> `dwell`+1. If `dwell` would exceed MAX_DWELL (MAX_DWELL≠0) -> stall (5).
  - Next phase ((p+1) mod 4) -> check the outgoing dwell against MIN_GREEN (p even) or MIN_YELLOW (p odd). If short -> short dwell (4). Otherwise `dwell`=1.
  - Any other valid phase -> sequence (3).
  - Bad pair -> 1 or 2, as classified above.
  - P3->P0 accepted -> `cycle_count`+1.
- **Fault priority when several causes apply in one sample:** 1 > 2 > 3 > 4 > 5.
- **FAULT:**
  - `fault`=1 and `fault_code` hold the first cause. Later violations are ignored.
  - `phase_valid`=0. `phase`, `dwell` and `cycle_count` freeze.
  - `clear` -> IDLE; `fault`/`fault_code` cleared; `dwell`=0.
- **`clear` outside FAULT:** no effect. A violation detected in the same cycle still faults.
- **`cycle_count`:** cleared only by `rst`, not by `clear`.
- **`dwell`:** saturates and never wraps.

## Timing
- **Reset values:** `phase`=0, `phase_valid`=0, `fault`=0, `fault_code`=0, `dwell`=0, `cycle_count`=0, FSM=IDLE, sample register=(00,00). The all-red reset value of the sample register is not evaluated as a fault on the first cycle after reset.
- **Latency:** a pair present before edge E is sampled at E. The outputs reflecting it (`phase`, `phase_valid`, `dwell`, `fault`, `fault_code`, `cycle_count`) update at edge E+1.
- **IDLE->TRACK:** `phase_valid` rises at E+1 of the first sampled P0.
- **`rst` mid-operation:** forces the reset values immediately, with no clock required. Resync needs a fresh P0.
- **`clear`:** sampled at the edge. The FAULT->IDLE transition and the `fault` drop occur at that edge. A pair sampled at the same edge is evaluated as IDLE input from the next edge onward.

## Test plan
- **Normal rotation:** rst low, drive the controller rotation P0,P1,P2,P3 repeating, one cycle each -> `phase_valid` rises 2 edges after the first P0, `fault` stays 0, `cycle_count`=3 after 3 full rotations, `dwell`=1 throughout.
- **Conflict:** in TRACK, drive (10,10) for one cycle -> `fault`=1 and `fault_code`=1 two edges later; a following (11,00) leaves the code at 1.
- **Sequence skip:** P0 then P2 -> `fault_code`=3; then pulse `clear`, drive P2,P3 (IDLE, no fault), then P0 -> `phase_valid`=1 again.
- **Stall:** MAX_DWELL=16, hold P0 for 17 samples -> `dwell` reads 16 and then `fault_code`=5 on the 17th sample's output edge. With MAX_DWELL=0, hold 300 samples -> no fault and `dwell`=255.
- **Short green:** MIN_GREEN=3, P0 for 2 samples then P1 -> `fault_code`=4. With P0 held 3 samples -> no fault.
- **Reset mid-fault:** in FAULT with `fault_code`=5 and `cycle_count`=7, assert `rst` between edges -> all outputs 0 immediately. After release, (00,00) for 3 cycles -> `fault` asserts with `fault_code`=2.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-approach signal-head bus.
// Decodes NS/EW codes to a phase and latches the first rule violation.
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 1,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_DWELL  = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ns_light,
  input  logic [1:0]       ew_light,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] dwell,
  output logic [15:0]      cycle_count
);

  localparam logic [CNT_W-1:0] MING = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MINY = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAXD = CNT_W'(MAX_DWELL);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FLT
  } state_t;

  state_t           state, state_n;
  logic [1:0]       s_ns, s_ew;
  logic             primed;
  logic [1:0]       phase_n;
  logic             pv_n, fault_n;
  logic [2:0]       code_n;
  logic [CNT_W-1:0] dwell_n;
  logic [15:0]      cc_n;

  logic             ok;
  logic [1:0]       ph;
  logic [2:0]       bad;
  logic [CNT_W-1:0] min_d;
  logic             stall;

  always_comb begin
    ok = 1'b1;
    ph = 2'd0;
    unique case ({s_ns, s_ew})
      4'b1000: ph = 2'd0;
      4'b0100: ph = 2'd1;
      4'b0010: ph = 2'd2;
      4'b0001: ph = 2'd3;
      default: ok = 1'b0;
    endcase
  end

  // Both heads showing a non-red aspect outranks an illegal code.
  assign bad   = (s_ns != 2'b00 && s_ew != 2'b00) ? 3'd1 : 3'd2;
  assign min_d = phase[0] ? MINY : MING;
  assign stall = (MAX_DWELL != 0) && (dwell >= MAXD);

  always_comb begin
    state_n = state;
    phase_n = phase;
    pv_n    = phase_valid;
    fault_n = fault;
    code_n  = fault_code;
    dwell_n = dwell;
    cc_n    = cycle_count;
    unique case (state)
      IDLE: begin
        if (primed) begin
          if (!ok) begin
            state_n = FLT;
            fault_n = 1'b1;
            code_n  = bad;
            pv_n    = 1'b0;
          end else if (ph == 2'd0) begin
            state_n = TRACK;
            phase_n = 2'd0;
            dwell_n = {{(CNT_W-1){1'b0}}, 1'b1};
            pv_n    = 1'b1;
          end
        end
      end
      TRACK: begin
        if (!ok) begin
          state_n = FLT;
          fault_n = 1'b1;
          code_n  = bad;
          pv_n    = 1'b0;
        end else if (ph == phase) begin
          if (stall) begin
            state_n = FLT;
            fault_n = 1'b1;
            code_n  = 3'd5;
            pv_n    = 1'b0;
          end else if (!(&dwell)) begin
            dwell_n = dwell + 1'b1;
          end
        end else if (ph == phase + 2'd1) begin
          if (dwell < min_d) begin
            state_n = FLT;
            fault_n = 1'b1;
            code_n  = 3'd4;
            pv_n    = 1'b0;
          end else begin
            phase_n = ph;
            dwell_n = {{(CNT_W-1){1'b0}}, 1'b1};
            if (phase == 2'd3) cc_n = cycle_count + 16'd1;
          end
        end else begin
          state_n = FLT;
          fault_n = 1'b1;
          code_n  = 3'd3;
          pv_n    = 1'b0;
        end
      end
      FLT: begin
        if (clear) begin
          state_n = IDLE;
          fault_n = 1'b0;
          code_n  = 3'd0;
          dwell_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s_ns        <= 2'b00;
      s_ew        <= 2'b00;
      primed      <= 1'b0;
      phase       <= 2'd0;
      phase_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      dwell       <= '0;
      cycle_count <= 16'd0;
    end else begin
      state       <= state_n;
      s_ns        <= ns_light;
      s_ew        <= ew_light;
      primed      <= 1'b1;
      phase       <= phase_n;
      phase_valid <= pv_n;
      fault       <= fault_n;
      fault_code  <= code_n;
      dwell       <= dwell_n;
      cycle_count <= cc_n;
    end
  end

endmodule
